// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with memory wait/timeout, illegal-op trap and retire pulse.
module mips_multicycle_control #(
    parameter bit EN_ADDI     = 1'b1,
    parameter bit EN_JUMP     = 1'b1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] state_o,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic       instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // Counter keeps at least one bit so MEM_TIMEOUT=0 (timeout disabled) still elaborates.
    localparam int            CW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    state_t        state, state_n;
    logic [CW-1:0] wcnt;
    logic          tmo_q;
    logic          mem_st;
    logic          abort;

    assign mem_st = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // Abort on the low cycle that brings the consecutive-wait count up to MEM_TIMEOUT.
    assign abort  = (MEM_TIMEOUT != 0) && mem_st && !mem_ready && (wcnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            wcnt  <= '0;
            tmo_q <= 1'b0;
        end else begin
            state <= state_n;
            tmo_q <= abort;
            if (mem_st && !mem_ready && !abort)
                wcnt <= (wcnt == CNT_MAX) ? wcnt : wcnt + 1'b1;
            else
                wcnt <= '0;
        end
    end

    always_comb begin
        state_n       = state;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSrc         = 2'b00;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;
        state_o       = state;
        mem_timeout   = tmo_q;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXEC;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_ADDI:      state_n = EN_ADDI ? S_ADDIEX : S_TRAP;
                    OP_J:         state_n = EN_JUMP ? S_JUMP : S_TRAP;
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite      = 1'b1;
                MemtoReg      = 1'b1;
                instr_retired = 1'b1;
                state_n       = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_n       = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite      = 1'b1;
                RegDst        = 1'b1;
                instr_retired = 1'b1;
                state_n       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCWriteCond   = 1'b1;
                PCSrc         = 2'b01;
                instr_retired = 1'b1;
                state_n       = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_n = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                state_n       = S_FETCH;
            end
            S_JUMP: begin
                PCWrite       = 1'b1;
                PCSrc         = 2'b10;
                instr_retired = 1'b1;
                state_n       = S_FETCH;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                state_n    = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
        if (abort) state_n = S_FETCH;
        // Outputs are forced quiet for the whole reset window, including before the first edge.
        if (reset) begin
            PCWrite       = 1'b0;
            PCWriteCond   = 1'b0;
            IorD          = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            MemtoReg      = 1'b0;
            RegDst        = 1'b0;
            RegWrite      = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = 2'b00;
            ALUOp         = 2'b00;
            PCSrc         = 2'b00;
            illegal_op    = 1'b0;
            instr_retired = 1'b0;
            state_o       = 4'd0;
            mem_timeout   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: two configurations driven in lockstep, a hand table,
// directed timeout/trap sequences and random traffic against a phase-queue reference model.
module tb_mips_multicycle_control;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    always #5 clk = ~clk;

    wire [1:0]      pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, ill, tmo, ret;
    wire [1:0][1:0] srcb, aluop, pcsrc;
    wire [1:0][3:0] st;

    mips_multicycle_control #(.EN_ADDI(1'b1), .EN_JUMP(1'b1), .MEM_TIMEOUT(15)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IorD(iord[0]), .MemRead(mr[0]),
        .MemWrite(mw[0]), .IRWrite(irw[0]), .MemtoReg(m2r[0]), .RegDst(rdst[0]),
        .RegWrite(rw[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .ALUOp(aluop[0]),
        .PCSrc(pcsrc[0]), .state_o(st[0]), .illegal_op(ill[0]), .mem_timeout(tmo[0]),
        .instr_retired(ret[0]));

    mips_multicycle_control #(.EN_ADDI(1'b0), .EN_JUMP(1'b0), .MEM_TIMEOUT(3)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IorD(iord[1]), .MemRead(mr[1]),
        .MemWrite(mw[1]), .IRWrite(irw[1]), .MemtoReg(m2r[1]), .RegDst(rdst[1]),
        .RegWrite(rw[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .ALUOp(aluop[1]),
        .PCSrc(pcsrc[1]), .state_o(st[1]), .illegal_op(ill[1]), .mem_timeout(tmo[1]),
        .instr_retired(ret[1]));

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic [3:0] st;
        logic ill, tmo, ret;
    } outs_t;

    typedef struct {
        bit         rst;
        logic [5:0] op;
        bit         rdy;
        logic [3:0] st;
        logic [5:0] fl;   // {RegWrite, MemWrite, IRWrite, instr_retired, illegal_op, mem_timeout}
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: current phase plus the list of phases still owed by this instruction.
    int m_cur[2], m_wait[2], m_pos[2], m_len[2];
    int m_seq[2][4];
    bit m_tmo[2];
    int  p_tmo[2]  = '{15, 3};
    bit  p_addi[2] = '{1'b1, 1'b0};
    bit  p_j[2]    = '{1'b1, 1'b0};

    bit         g_rst;
    logic [5:0] g_op;
    bit         g_rdy;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    function automatic outs_t act(input int k);
        outs_t o;
        o = '{pcw[k], pcwc[k], iord[k], mr[k], mw[k], irw[k], m2r[k], rdst[k], rw[k], srca[k],
              srcb[k], aluop[k], pcsrc[k], st[k], ill[k], tmo[k], ret[k]};
        return o;
    endfunction

    function automatic logic [5:0] flags0();
        return {rw[0], mw[0], irw[0], ret[0], ill[0], tmo[0]};
    endfunction

    function automatic outs_t model_out(input int k, input bit rst, input bit rdy);
        outs_t e = '0;
        if (rst) return e;
        e.st  = 4'(m_cur[k]);
        e.tmo = m_tmo[k];
        case (m_cur[k])
            0:  begin e.mr = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            1:  e.srcb = 2'b11;
            2:  begin e.srca = 1; e.srcb = 2'b10; end
            3:  begin e.mr = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; e.ret = 1; end
            5:  begin e.mw = 1; e.iord = 1; e.ret = rdy; end
            6:  begin e.srca = 1; e.aluop = 2'b10; end
            7:  begin e.rw = 1; e.rdst = 1; e.ret = 1; end
            8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; e.ret = 1; end
            9:  begin e.srca = 1; e.srcb = 2'b10; end
            10: begin e.rw = 1; e.ret = 1; end
            11: begin e.pcw = 1; e.pcsrc = 2'b10; e.ret = 1; end
            12: e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic void load(input int k, input int a, input int b, input int n);
        m_seq[k][0] = a; m_seq[k][1] = b; m_len[k] = n; m_pos[k] = 0;
    endfunction

    function automatic void next_phase(input int k);
        if (m_pos[k] < m_len[k]) begin
            m_cur[k] = m_seq[k][m_pos[k]];
            m_pos[k]++;
        end else m_cur[k] = 0;
    endfunction

    function automatic void model_step(input int k, input bit rst, input logic [5:0] op, input bit rdy);
        if (rst) begin
            m_cur[k] = 0; m_wait[k] = 0; m_tmo[k] = 0; load(k, 0, 0, 0);
            return;
        end
        m_tmo[k] = 0;
        if (m_cur[k] == 0 || m_cur[k] == 3 || m_cur[k] == 5) begin
            if (rdy) begin
                m_wait[k] = 0;
                if (m_cur[k] == 0) m_cur[k] = 1; else next_phase(k);
            end else begin
                m_wait[k]++;
                if (p_tmo[k] != 0 && m_wait[k] == p_tmo[k]) begin
                    m_cur[k] = 0; m_wait[k] = 0; m_tmo[k] = 1; load(k, 0, 0, 0);
                end
            end
        end else if (m_cur[k] == 1) begin
            if (op == LW || op == SW)       load(k, 2, 0, 1);
            else if (op == RT)              load(k, 6, 7, 2);
            else if (op == BEQ)             load(k, 8, 0, 1);
            else if (op == ADDI && p_addi[k]) load(k, 9, 10, 2);
            else if (op == JMP && p_j[k])   load(k, 11, 0, 1);
            else                            load(k, 12, 0, 1);
            next_phase(k);
        end else if (m_cur[k] == 2) begin
            if (op == LW) begin m_cur[k] = 3; load(k, 4, 0, 1); end
            else begin m_cur[k] = 5; load(k, 0, 0, 0); end
        end else next_phase(k);
    endfunction

    task automatic apply(input bit rst, input logic [5:0] op, input bit rdy);
        reset = rst; opcode = op; mem_ready = rdy;
        g_rst = rst; g_op = op; g_rdy = rdy;
        #2;
        for (int k = 0; k < 2; k++)
            check($sformatf("model%0d_t%0t", k, $time), 32'(act(k)), 32'(model_out(k, rst, rdy)));
    endtask

    task automatic adv();
        for (int k = 0; k < 2; k++) model_step(k, g_rst, g_op, g_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit rst, input logic [5:0] op, input bit rdy);
        apply(rst, op, rdy);
        adv();
    endtask

    vec_t tbl[$];
    task automatic add(input bit r, input logic [5:0] o, input bit y, input logic [3:0] s, input logic [5:0] f);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = y; v.st = s; v.fl = f;
        tbl.push_back(v);
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 7))
            0: return LW;
            1: return SW;
            2: return RT;
            3: return BEQ;
            4: return ADDI;
            5: return JMP;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0] rop;
        bit         rrdy;
        bit         rrst;
        for (int k = 0; k < 2; k++) model_step(k, 1'b1, 6'h00, 1'b0);

        add(1, RT, 1, 0, 6'b000000);  add(1, RT, 1, 0, 6'b000000);
        add(0, LW, 1, 0, 6'b001000);  add(0, LW, 1, 1, 6'b000000);
        add(0, LW, 1, 2, 6'b000000);  add(0, LW, 1, 3, 6'b000000);
        add(0, LW, 1, 4, 6'b100100);
        add(0, SW, 1, 0, 6'b001000);  add(0, SW, 1, 1, 6'b000000);
        add(0, SW, 1, 2, 6'b000000);  add(0, SW, 0, 5, 6'b010000);
        add(0, SW, 0, 5, 6'b010000);  add(0, SW, 0, 5, 6'b010000);
        add(0, SW, 1, 5, 6'b010100);
        add(0, RT, 1, 0, 6'b001000);  add(0, RT, 1, 1, 6'b000000);
        add(0, RT, 1, 6, 6'b000000);  add(0, RT, 1, 7, 6'b100100);
        add(0, BEQ, 1, 0, 6'b001000); add(0, BEQ, 1, 1, 6'b000000);
        add(0, BEQ, 1, 8, 6'b000100);
        add(0, 6'h3F, 1, 0, 6'b001000); add(0, 6'h3F, 1, 1, 6'b000000);
        add(0, 6'h3F, 1, 12, 6'b000010);
        add(0, JMP, 0, 0, 6'b000000); add(0, JMP, 1, 0, 6'b001000);
        add(0, JMP, 1, 1, 6'b000000); add(0, JMP, 1, 11, 6'b000100);
        add(0, ADDI, 1, 0, 6'b001000); add(0, ADDI, 1, 1, 6'b000000);
        add(0, ADDI, 1, 9, 6'b000000); add(0, ADDI, 1, 10, 6'b100100);
        add(0, LW, 1, 0, 6'b001000);  add(0, LW, 1, 1, 6'b000000);
        add(1, LW, 1, 0, 6'b000000);  add(0, LW, 0, 0, 6'b000000);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].op, tbl[i].rdy);
            check($sformatf("tbl%0d_state", i), 32'(st[0]), 32'(tbl[i].st));
            check($sformatf("tbl%0d_flags", i), 32'(flags0()), 32'(tbl[i].fl));
            adv();
        end

        // LW with memory never answering: abort after 15 waiting cycles.
        cyc(1, LW, 1); cyc(0, LW, 1); cyc(0, LW, 1); cyc(0, LW, 1);
        for (int i = 0; i < 15; i++) begin
            apply(0, LW, 0);
            check($sformatf("tmo_wait%0d", i), {31'd0, tmo[0]} | 32'(st[0]) << 4, 32'h30);
            adv();
        end
        apply(0, LW, 0);
        check("tmo_state", 32'(st[0]), 32'd0);
        check("tmo_pulse", 32'(tmo[0]), 32'd1);
        check("tmo_no_regwrite", 32'(rw[0]), 32'd0);
        adv();

        // mem_ready on the 15th waiting cycle completes instead of aborting.
        cyc(1, LW, 1); cyc(0, LW, 1); cyc(0, LW, 1); cyc(0, LW, 1);
        for (int i = 0; i < 14; i++) cyc(0, LW, 0);
        apply(0, LW, 1);
        check("edge_state", 32'(st[0]), 32'd3);
        adv();
        apply(0, LW, 1);
        check("edge_memwb", 32'(st[0]), 32'd4);
        check("edge_regwrite", 32'(rw[0]), 32'd1);
        check("edge_no_tmo", 32'(tmo[0]), 32'd0);
        adv();

        // Disabled ADDI and J trap on the second configuration.
        cyc(1, ADDI, 1); cyc(0, ADDI, 1); cyc(0, ADDI, 1);
        apply(0, ADDI, 1);
        check("addi_trap_state", 32'(st[1]), 32'd12);
        check("addi_trap_ill", 32'(ill[1]), 32'd1);
        check("addi_trap_en", 32'({rw[1], mw[1]}), 32'd0);
        adv();
        apply(0, JMP, 1);
        check("trap_exit_state", 32'(st[1]), 32'd0);
        check("trap_exit_ill", 32'(ill[1]), 32'd0);
        adv();
        cyc(0, JMP, 1);
        apply(0, JMP, 1);
        check("j_trap_state", 32'(st[1]), 32'd12);
        check("j_trap_pcw", 32'({pcw[1], ret[1]}), 32'd0);
        adv();

        rop = RT;
        for (int i = 0; i < 4000; i++) begin
            if ((i / 300) % 2 == 0) rrdy = ($urandom_range(0, 3) != 0);
            else                    rrdy = ($urandom_range(0, 7) == 0);
            rrst = ($urandom_range(0, 249) == 0);
            if ((m_cur[0] == 0 || m_cur[0] == 12) && (m_cur[1] == 0 || m_cur[1] == 12)
                && $urandom_range(0, 1) == 1)
                rop = rand_op();
            cyc(rrst, rop, rrdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder: a Moore FSM sequencing fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one unified memory.
- Adds variable-latency memory handshake (mem_ready), optional ADDI/J support, illegal-opcode trap and an instruction-retired pulse.
- Sits between the instruction register opcode field and the multicycle datapath muxes/enables.
- ALUOp encoding is unchanged (00 add, 01 sub, 10 funct), so the existing ALU_Control is reused as-is.

Parameters:
- EN_ADDI, 1, 1 = decode ADDI (001000); 0 = treat it as illegal.
- EN_JUMP, 1, 1 = decode J (000010); 0 = treat it as illegal.
- MEM_TIMEOUT, 15, maximum cycles a memory state waits for mem_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the access in this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (BEQ)
- IorD  out  1  0 = address from PC, 1 = address from ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback data select (1 = MDR)
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = ImmExt, 11 = ImmExt<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state_o  out  4  current state encoding, for debug
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- mem_timeout  out  1  one-cycle pulse on a memory abort
- instr_retired  out  1  one-cycle pulse when an instruction completes

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12. Codes 13–15 go to FETCH on the next clock.
- Reset: while reset=1, state is forced to FETCH, the wait counter clears, and every output is 0 (state_o=0). The first fetch is issued in the cycle after reset deasserts. Asserting reset mid-instruction aborts it on that edge; no partial write is retired.
- Moore outputs decode from the current state only; unlisted outputs are 0. The exception is the memory-completion enables, which are gated by mem_ready as noted.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1; the FSM then goes to DECODE. Otherwise it holds in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW → MEMADR
  - R-type → EXEC
  - BEQ → BRANCH
  - ADDI → ADDIEX
  - J → JUMP
  - anything else, or a disabled opcode → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_retired=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready; on that cycle instr_retired=1 and the FSM goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_retired=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01, instr_retired=1 → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_retired=1 → FETCH.
- JUMP: PCWrite=1, PCSrc=10, instr_retired=1 → FETCH.
- TRAP: illegal_op=1, all enables 0, no retire → FETCH. The PC was already incremented in FETCH, so the bad instruction is skipped.
- Wait counter (applies in FETCH, MEMRD, MEMWR):
  - Counts consecutive cycles with mem_ready=0 and clears on entry to any memory state.
  - When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT, the next cycle goes to FETCH with mem_timeout=1; no enables fire and no retire pulse is issued.
  - mem_ready=1 on the same cycle as the count reaching MEM_TIMEOUT: completion wins.
  - The counter saturates and does not wrap; its width is clog2(MEM_TIMEOUT+1).
- mem_ready outside memory states is ignored.
- Cycle counts with zero wait states: R-type, ADDI and SW = 4; LW = 5; BEQ and J = 3. Each extra cycle with mem_ready low adds 1.

Test Plan:
- reset=1 for 2 cycles with mem_ready=1 → all outputs 0. After release, FETCH is entered with MemRead=1, IRWrite=1, PCWrite=1; state_o sequence is 0,1.
- LW (100011), mem_ready tied 1 → states 0,1,2,3,4. MEMWB drives RegWrite=1, MemtoReg=1. instr_retired pulses once, 5 cycles after fetch start.
- SW, mem_ready low for 3 cycles in MEMWR → MemWrite=1, IorD=1 held for 4 cycles. instr_retired fires on the mem_ready cycle and RegWrite never rises.
- R-type (000000) then BEQ (000100) → ALUWB has RegDst=1, RegWrite=1; BRANCH has ALUOp=01, PCWriteCond=1, PCSrc=01. Totals are 4 and 3 cycles.
- Opcode 111111, then ADDI with EN_ADDI=0 → TRAP, illegal_op=1 for 1 cycle each, no RegWrite/MemWrite, then FETCH.
- MEM_TIMEOUT=15, mem_ready held low in MEMRD → FETCH after 15 waiting cycles, mem_timeout=1, no RegWrite. A second run raises mem_ready on the 15th cycle → MEMWB is taken and mem_timeout stays 0.
